// File: rtl/lms_tdm_sequencer.sv
// lms_tdm_sequencer: time-multiplexed LMS adaptive FIR engine.
// A single shared multiplier is scheduled through the filter phase (FILT),
// error computation (ERR) and weight update (UPD) for each accepted sample.
// Optional feature macro: LMS_FREEZE_EN adds a 'freeze' input, sampled in ERR,
// which skips the weight update for that sample.
module lms_tdm_sequencer #(
  parameter int TAPS     = 4,
  parameter int DW       = 16,
  parameter int WW       = 16,
  parameter int MU_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DW-1:0]        x_in,
  input  logic signed [DW-1:0]        d_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DW-1:0]        y_out,
  output logic signed [DW-1:0]        e_out,
  output logic                        busy,
  input  logic [$clog2(TAPS)-1:0]     w_rd_idx,
`ifdef LMS_FREEZE_EN
  input  logic                        freeze,
`endif
  output logic signed [WW-1:0]        w_rd_data
);

  localparam int IW = $clog2(TAPS);
  localparam int MW = (DW > WW) ? DW : WW;  // shared multiplier operand A width
  localparam int PW = MW + DW;              // product width
  localparam int AW = DW + WW + IW;         // accumulator width, overflow-free

  typedef enum logic [2:0] {IDLE, FILT, ERR, UPD, OUT} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         k_q, k_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]  xd_q [TAPS];
  logic signed [DW-1:0]  xd_d [TAPS];
  logic signed [WW-1:0]  w_q  [TAPS];
  logic signed [WW-1:0]  w_d  [TAPS];
  logic signed [DW-1:0]  dl_q, dl_d;
  logic signed [DW-1:0]  y_q, y_d;
  logic signed [DW-1:0]  e_q, e_d;

  logic signed [MW-1:0]  mul_a;
  logic signed [DW-1:0]  mul_b;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  upd;
  logic signed [PW:0]    wsum;
  logic signed [DW-1:0]  y_sat;
  logic signed [DW:0]    diff;
  logic signed [DW-1:0]  e_sat;
  logic                  last_tap;

  // Clamp an accumulator-width value into signed DW range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    if ((&v[AW-1:DW-1]) || !(|v[AW-1:DW-1]))
      return v[DW-1:0];
    else if (v[AW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  // Clamp a weight-update sum into signed WW range.
  function automatic logic signed [WW-1:0] sat_ww(input logic signed [PW:0] v);
    if ((&v[PW:WW-1]) || !(|v[PW:WW-1]))
      return v[WW-1:0];
    else if (v[PW])
      return {1'b1, {(WW-1){1'b0}}};
    else
      return {1'b0, {(WW-1){1'b1}}};
  endfunction

  // Shared multiplier and the arithmetic around it; operand A is the weight in
  // FILT and the registered error in UPD, operand B is always the delayed x.
  always_comb begin
    mul_a    = (state_q == UPD) ? MW'(e_q) : MW'(w_q[k_q]);
    mul_b    = xd_q[k_q];
    prod     = PW'(mul_a) * PW'(mul_b);
    upd      = prod >>> MU_SHIFT;
    wsum     = (PW+1)'(w_q[k_q]) + (PW+1)'(upd);
    y_sat    = sat_dw(acc_q);
    diff     = (DW+1)'(dl_q) - (DW+1)'(y_sat);
    e_sat    = sat_dw(AW'(diff));
    last_tap = (k_q == IW'(TAPS-1));
  end

  // Next-state and datapath sequencing for the five-state schedule.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    xd_d    = xd_q;
    w_d     = w_q;
    dl_d    = dl_q;
    y_d     = y_q;
    e_d     = e_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          xd_d[0] = x_in;
          for (int i = 1; i < TAPS; i++) xd_d[i] = xd_q[i-1];
          dl_d    = d_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = FILT;
        end
      end
      FILT: begin
        acc_d = acc_q + AW'(prod);
        if (last_tap) begin
          k_d     = '0;
          state_d = ERR;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ERR: begin
        y_d     = y_sat;
        e_d     = e_sat;
        k_d     = '0;
`ifdef LMS_FREEZE_EN
        state_d = freeze ? OUT : UPD;
`else
        state_d = UPD;
`endif
      end
      UPD: begin
        w_d[k_q] = sat_ww(wsum);
        if (last_tap) begin
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, delay line, weights and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      xd_q    <= '{default: '0};
      w_q     <= '{default: '0};
      dl_q    <= '0;
      y_q     <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      xd_q    <= xd_d;
      w_q     <= w_d;
      dl_q    <= dl_d;
      y_q     <= y_d;
      e_q     <= e_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign y_out     = y_q;
  assign e_out     = e_q;
  assign w_rd_data = w_q[w_rd_idx];

endmodule

// File: tb/tb_lms_tdm_sequencer.sv
// Directed testbench for lms_tdm_sequencer (TAPS=4, DW=WW=16, MU_SHIFT=2).
module tb_lms_tdm_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] x_in;
  logic signed [15:0] d_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] y_out;
  logic signed [15:0] e_out;
  logic               busy;
  logic [1:0]         w_rd_idx;
  logic signed [15:0] w_rd_data;
`ifdef LMS_FREEZE_EN
  logic               freeze;
`endif

  int n_run  = 0;
  int n_fail = 0;
  int lat;
  int stall_bad;
  int ov_seen;

  always #5 clk = ~clk;

  lms_tdm_sequencer #(.TAPS(4), .DW(16), .WW(16), .MU_SHIFT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .e_out     (e_out),
    .busy      (busy),
    .w_rd_idx  (w_rd_idx),
`ifdef LMS_FREEZE_EN
    .freeze    (freeze),
`endif
    .w_rd_data (w_rd_data)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_w(input string tag, input int e0, input int e1,
                         input int e2, input int e3);
    int ev [4];
    ev = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      w_rd_idx = 2'(i);
      #1;
      check($sformatf("%s_w%0d", tag, i), w_rd_data, ev[i]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Offer one sample (accepted at the next edge) and count edges to out_valid.
  task automatic send(input int x, input int d, output int l);
    in_valid = 1'b1;
    x_in     = 16'(x);
    d_in     = 16'(d);
    tick();
    in_valid = 1'b0;
    l = 0;
    while (!out_valid && l < 40) begin
      tick();
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x_in = '0; d_in = '0; w_rd_idx = '0;
`ifdef LMS_FREEZE_EN
    freeze = 1'b0;
`endif
    tick(); tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y_out, 0);
    check("rst_e", e_out, 0);
    check_w("rst", 0, 0, 0, 0);

`ifdef LMS_FREEZE_EN
    freeze = 1'b1;
    send(4, 8, lat);
    check("frz_lat", lat, 5);
    check("frz_y", y_out, 0);
    check("frz_e", e_out, 8);
    check_w("frz", 0, 0, 0, 0);
    tick();
    freeze = 1'b0;
    do_reset();
`endif

    // Sample A: x=4, d=8 from zero weights
    send(4, 8, lat);
    check("a_lat", lat, 9);
    check("a_y", y_out, 0);
    check("a_e", e_out, 8);
    check_w("a", 8, 0, 0, 0);
    tick();
    check("a_idle", busy, 0);

    // Sample B with consumer stalled
    out_ready = 1'b0;
    send(4, 8, lat);
    check("b_lat", lat, 9);
    check("b_y", y_out, 32);
    check("b_e", e_out, -24);
    check_w("b", -16, -24, 0, 0);

    in_valid = 1'b1; x_in = 16'sd100; d_in = 16'sd0;
    stall_bad = 0;
    repeat (20) begin
      tick();
      if (!out_valid || y_out !== 16'sd32 || e_out !== -16'sd24 || in_ready)
        stall_bad++;
    end
    check("stall_hold", stall_bad, 0);
    check_w("stall", -16, -24, 0, 0);

    out_ready = 1'b1;
    tick();
    check("rel_busy", busy, 0);
    check("rel_out_valid", out_valid, 0);
    check("rel_in_ready", in_ready, 1);
    tick();
    check("rel_accept", busy, 1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("c_lat", lat, 9);
    check("c_y", y_out, -1696);
    check("c_e", e_out, 1696);
    check_w("c", 32767, 1672, 1696, 0);
    tick();

    // Negative update term rounds toward -inf
    do_reset();
    send(-3, 1, lat);
    check("neg_y", y_out, 0);
    check("neg_e", e_out, 1);
    check_w("neg", -1, 0, 0, 0);
    tick();

    // Reset during UPD after two tap updates
    in_valid = 1'b1; x_in = 16'sd4; d_in = 16'sd8;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check_w("mid", 11, -9, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_out_valid", out_valid, 0);
    check("ab_in_ready", in_ready, 1);
    check_w("ab", 0, 0, 0, 0);
    ov_seen = 0;
    repeat (15) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("ab_no_output", ov_seen, 0);

    // Saturation of y, e and weights
    do_reset();
    send(32767, 32767, lat);
    check("s1_y", y_out, 0);
    check("s1_e", e_out, 32767);
    check_w("s1", 32767, 0, 0, 0);
    tick();
    send(32767, 32767, lat);
    check("s2_y", y_out, 32767);
    check("s2_e", e_out, 0);
    tick();
    send(32767, -32768, lat);
    check("s3_y", y_out, 32767);
    check("s3_e", e_out, -32768);
    check_w("s3", -32768, -32768, -32768, 0);
    tick();
    send(-32768, 32767, lat);
    check("s4_y", y_out, -32768);
    check("s4_e", e_out, 32767);
    check_w("s4", -32768, 32767, 32767, 32767);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
